// File: rtl/instram_loader.sv
// Framed serial loader for the 6502 instruction RAM: parses sync/address/length/payload/checksum
// bytes from the UART receiver, writes the payload and holds the CPU in reset until a good frame.
//
// state  | meaning
// S_SYNC | idle, waiting for 0xA5
// S_ADR_L| expecting start address low byte
// S_ADR_H| expecting start address high byte
// S_LEN_L| expecting payload length low byte
// S_LEN_H| expecting payload length high byte
// S_DATA | receiving payload bytes
// S_CSUM | expecting checksum byte
module instram_loader #(
    parameter int unsigned TIMEOUT   = 1000000,
    parameter bit          BOOT_HOLD = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] ram_adr_w,
    output logic [7:0]  ram_data,
    output logic        ram_rwn,
    output logic        ram_cs,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned     TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]   TMR_LOAD = TW'(TIMEOUT - 1);
    localparam logic [7:0]      SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_ADR_L = 3'd1,
        S_ADR_H = 3'd2,
        S_LEN_L = 3'd3,
        S_LEN_H = 3'd4,
        S_DATA  = 3'd5,
        S_CSUM  = 3'd6
    } state_t;

    state_t         state_q, state_d;

    logic [15:0]    adr_q;
    logic [15:0]    len_q;
    logic [7:0]     sum_q;
    logic [TW-1:0]  tmr_q;

    logic           wr_pend_q;
    logic [15:0]    wr_adr_q;
    logic [15:0]    ram_adr_w_q;
    logic [7:0]     ram_data_q;
    logic           ram_cs_q;

    logic           fin_pend_q;
    logic           fin_ok_q;
    logic           busy_q;
    logic           done_q;
    logic           err_q;
    logic           cpu_rst_n_q;

    logic           sync_hit;
    logic           data_hit;
    logic           csum_hit;
    logic           tmo_hit;
    logic           len_zero;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        if (tmo_hit) begin
            state_d = S_SYNC;
        end else if (rx_valid) begin
            case (state_q)
                S_SYNC:  if (rx_data == SYNC_BYTE) state_d = S_ADR_L;
                S_ADR_L: state_d = S_ADR_H;
                S_ADR_H: state_d = S_LEN_L;
                S_LEN_L: state_d = S_LEN_H;
                S_LEN_H: state_d = len_zero ? S_CSUM : S_DATA;
                S_DATA:  if (len_q == 16'd1) state_d = S_CSUM;
                S_CSUM:  state_d = S_SYNC;
                default: state_d = S_SYNC;
            endcase
        end
    end

    // ---------------------------------------------------------------- decoded events
    always_comb begin
        sync_hit = 1'b0;
        data_hit = 1'b0;
        csum_hit = 1'b0;
        tmo_hit  = 1'b0;
        len_zero = ({rx_data, len_q[7:0]} == 16'h0000);
        if (rx_valid) begin
            sync_hit = (state_q == S_SYNC) && (rx_data == SYNC_BYTE);
            data_hit = (state_q == S_DATA);
            csum_hit = (state_q == S_CSUM);
        end else begin
            tmo_hit  = (state_q != S_SYNC) && (tmr_q == '0);
        end
    end

    // ---------------------------------------------------------------- frame header / running sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q <= 16'h0000;
            len_q <= 16'h0000;
            sum_q <= 8'h00;
        end else if (rx_valid) begin
            case (state_q)
                S_SYNC:  sum_q <= 8'h00;
                S_ADR_L: adr_q[7:0]  <= rx_data;
                S_ADR_H: adr_q[15:8] <= rx_data;
                S_LEN_L: len_q[7:0]  <= rx_data;
                S_LEN_H: len_q[15:8] <= rx_data;
                S_DATA: begin
                    adr_q <= adr_q + 16'd1;
                    len_q <= len_q - 16'd1;
                    sum_q <= sum_q + rx_data;
                end
                default: ;
            endcase
        end
    end

    // Inter-byte idle timer: reloaded by every byte, terminal count at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= TMR_LOAD;
        end else if (rx_valid) begin
            tmr_q <= TMR_LOAD;
        end else if ((state_q != S_SYNC) && (tmr_q != '0)) begin
            tmr_q <= tmr_q - 1'b1;
        end
    end

    // RAM registers write data internally, so data leads the address/strobe by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pend_q   <= 1'b0;
            wr_adr_q    <= 16'h0000;
            ram_data_q  <= 8'h00;
            ram_cs_q    <= 1'b0;
            ram_adr_w_q <= 16'h0000;
        end else begin
            wr_pend_q <= data_hit;
            ram_cs_q  <= wr_pend_q;
            if (data_hit) begin
                wr_adr_q   <= adr_q;
                ram_data_q <= rx_data;
            end
            if (wr_pend_q) begin
                ram_adr_w_q <= wr_adr_q;
            end
        end
    end

    // Frame verdict is applied one cycle after the checksum byte so the last write strobe
    // always precedes CPU release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_pend_q  <= 1'b0;
            fin_ok_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= ~BOOT_HOLD;
        end else begin
            fin_pend_q <= csum_hit;
            if (csum_hit) begin
                fin_ok_q <= (rx_data == sum_q);
            end
            done_q <= fin_pend_q && fin_ok_q;
            if (fin_pend_q) begin
                busy_q <= 1'b0;
                if (fin_ok_q) begin
                    cpu_rst_n_q <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (tmo_hit) begin
                busy_q <= 1'b0;
                err_q  <= 1'b1;
            end
            if (sync_hit) begin
                busy_q      <= 1'b1;
                err_q       <= 1'b0;
                cpu_rst_n_q <= 1'b0;
            end
        end
    end

    assign ram_adr_w = ram_adr_w_q;
    assign ram_data  = ram_data_q;
    assign ram_cs    = ram_cs_q;
    assign ram_rwn   = ~ram_cs_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
